// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared types and WM8731 bring-up command table for the I2C init path
// Rev    : 1.0  initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    START       = 3'd2,
    WAIT_ACCEPT = 3'd3,
    WAIT_DONE   = 3'd4,
    GAP         = 3'd5,
    DONE        = 3'd6,
    ERROR       = 3'd7
  } seq_state_t;

  localparam logic [7:0] WM8731_DEV_ADDR = 8'h34;
  localparam int         NUM_CMDS        = 11;

  // Entry 0 resets the codec; the rest configure it in register order.
  localparam logic [15:0] WM8731_CMD_TABLE [0:NUM_CMDS-1] = '{
    16'h1E00, 16'h0097, 16'h0297, 16'h0479, 16'h0679, 16'h0815,
    16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201
  };

endpackage
`default_nettype wire

// File: rtl/wm8731_cmd_rom.sv
`default_nettype none
// ============================================================================
// Module : wm8731_cmd_rom
// Brief  : Combinational index-to-register-word lookup into the codec table
// Rev    : 1.0  initial release
// ============================================================================
module wm8731_cmd_rom
  import i2c_pkg::*;
(
  input  logic [3:0]  i_idx,
  output logic [15:0] o_word
);

  always_comb begin
    o_word = 16'h0000;
    if (i_idx < 4'(NUM_CMDS)) o_word = WM8731_CMD_TABLE[i_idx];
  end

endmodule
`default_nettype wire

// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module : i2c_init_sequencer
// Brief  : Walks the WM8731 command table, handing frames to the I2C sender
// Rev    : 1.0  initial release
// ============================================================================
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int         BYTE           = 3,
  parameter logic [7:0] DEV_ADDR       = i2c_pkg::WM8731_DEV_ADDR,
  parameter int         NUM_CMDS       = i2c_pkg::NUM_CMDS,
  parameter int         GAP_CYCLES     = 4,
  parameter int         ACCEPT_TIMEOUT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_sender_finished,
  output logic              o_sender_start,
  output logic [BYTE*8-1:0] o_sender_dat,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [3:0]        o_cmd_idx
);

  localparam int c_gap_w = $clog2(GAP_CYCLES) + 1;
  localparam int c_to_w  = $clog2(ACCEPT_TIMEOUT) + 1;
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);
  localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(ACCEPT_TIMEOUT - 1);
  localparam logic [3:0]         c_last_idx = 4'(NUM_CMDS - 1);

  seq_state_t           r_state;
  logic [c_gap_w-1:0]   r_gap_cnt;
  logic [c_to_w-1:0]    r_to_cnt;
  logic [15:0]          w_word;
  logic [BYTE*8-1:0]    w_frame;

  wm8731_cmd_rom u_rom (
    .i_idx  (o_cmd_idx),
    .o_word (w_word)
  );

  assign w_frame = (BYTE*8)'({DEV_ADDR, w_word});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      o_sender_start <= 1'b0;
      o_sender_dat   <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_cmd_idx      <= 4'd0;
      r_gap_cnt      <= '0;
      r_to_cnt       <= '0;
    end else begin
      o_sender_start <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            r_state   <= LOAD;
            o_cmd_idx <= 4'd0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        // Frame is only refreshed once the sender is idle, so it never moves under an active transfer.
        LOAD: begin
          if (i_sender_finished) begin
            o_sender_dat   <= w_frame;
            o_sender_start <= 1'b1;
            r_state        <= START;
          end
        end
        START: begin
          r_to_cnt <= '0;
          r_state  <= WAIT_ACCEPT;
        end
        WAIT_ACCEPT: begin
          if (!i_sender_finished) begin
            r_state <= WAIT_DONE;
          end else if (r_to_cnt == c_to_last) begin
            r_state <= ERROR;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (i_sender_finished) begin
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            if (o_cmd_idx == c_last_idx) begin
              r_state <= DONE;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              o_cmd_idx <= o_cmd_idx + 4'd1;
              r_state   <= LOAD;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
